// File: rtl/uart_pkg.sv
// Shared UART defaults and the FSM state encoding used by both the tx and rx paths.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE = 115_200;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    // Bit-period counter width; runs 0 .. clks_per_bit-1.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_tx_rx_if.sv
// Parallel-side handshake of the UART: transmit request/data/busy and receive done/data.
interface uart_tx_rx_if;

    logic       tx_st;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       done;
    logic [7:0] rx_data;

    modport master (
        output tx_st,
        output tx_data,
        input  tx_busy,
        input  done,
        input  rx_data
    );

    modport slave (
        input  tx_st,
        input  tx_data,
        output tx_busy,
        output done,
        output rx_data
    );

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered serial and busy outputs.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_st,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_serial
);

    localparam int unsigned     CntW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    uart_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            bit_end;

    assign bit_end = (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_busy   <= 1'b0;
            tx_serial <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tx_st) begin
                        shift_q   <= tx_data;
                        cnt_q     <= '0;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        tx_serial <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_serial <= 1'b1;
                            state_q   <= StStop;
                        end else begin
                            bit_q     <= bit_q + 1'b1;
                            tx_serial <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    // One idle cycle follows; a request seen there starts the next frame at once.
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_busy <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_rx.sv
// UART top: instantiates the transmitter and holds the mid-bit sampling receiver.
module uart_tx_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE    = DEFAULT_BAUD_RATE,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_rx_if.slave bus,
    output logic        tx_serial,
    input  logic        rx_serial
);

    localparam int unsigned     CntW    = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfMax = CntW'((CLKS_PER_BIT - 1) / 2);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_st    (bus.tx_st),
        .tx_data  (bus.tx_data),
        .tx_busy  (bus.tx_busy),
        .tx_serial(tx_serial)
    );

    logic [1:0]      sync_q;
    logic            rx_s;
    uart_state_e     rx_state_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic [7:0]      rx_data_q;
    logic            done_q;
    logic            wait_high_q;

    assign rx_s        = sync_q[1];
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= 2'b11;
            rx_state_q  <= StIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= 8'h00;
            done_q      <= 1'b0;
            wait_high_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_serial};
            done_q <= 1'b0;
            case (rx_state_q)
                StIdle: begin
                    // After a framing error the line must go high before a new start counts.
                    if (wait_high_q) begin
                        if (rx_s) wait_high_q <= 1'b0;
                    end else if (!rx_s) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= StStart;
                    end
                end
                StStart: begin
                    if (rx_cnt_q == HalfMax) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_state_q <= rx_s ? StIdle : StData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (rx_cnt_q == CntMax) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= StStop;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (rx_cnt_q == CntMax) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= StIdle;
                        if (rx_s) begin
                            rx_data_q <= rx_shift_q;
                            done_q    <= 1'b1;
                        end else begin
                            wait_high_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_rx.sv
// Bench: instance A transmits at the nominal clock, instance B receives on a 1% slower clock.
module tb_uart_tx_rx;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned BAUD_RATE = 3_125_000;
    localparam int unsigned N         = CLK_FREQ / BAUD_RATE;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    logic rst   = 1'b1;

    always #100 clk_a = ~clk_a;
    always #101 clk_b = ~clk_b;

    uart_tx_rx_if bus_a ();
    uart_tx_rx_if bus_b ();

    logic a_tx_serial, b_tx_serial, line_b;
    logic tb_line   = 1'b1;
    logic drive_sel = 1'b0;

    assign line_b = drive_sel ? tb_line : a_tx_serial;

    uart_tx_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_a (
        .clk      (clk_a),
        .rst      (rst),
        .bus      (bus_a),
        .tx_serial(a_tx_serial),
        .rx_serial(b_tx_serial)
    );

    uart_tx_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_b (
        .clk      (clk_b),
        .rst      (rst),
        .bus      (bus_b),
        .tx_serial(b_tx_serial),
        .rx_serial(line_b)
    );

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [9:0] frame;
    } vec_t;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step_a();
        @(posedge clk_a);
        #1;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (bus_a.tx_busy && n < 12 * N) begin
            step_a();
            n++;
        end
        if (bus_a.tx_busy) begin
            checks++;
            errors++;
            $display("FAIL tx_idle_timeout actual=busy required=idle");
        end
    endtask

    // Leaves the caller #1 after the edge that sampled tx_st.
    task automatic start_tx(input logic [7:0] d);
        wait_idle_a();
        step_a();
        bus_a.tx_st   = 1'b1;
        bus_a.tx_data = d;
        step_a();
        bus_a.tx_st = 1'b0;
        check("tx_busy_rise", bus_a.tx_busy, 1);
        check("tx_start_low", a_tx_serial, 0);
    endtask

    task automatic send_rx_frame(input logic [7:0] d, input logic stop);
        tb_line = 1'b0;
        repeat (N) step_a();
        for (int b = 0; b < 8; b++) begin
            tb_line = d[b];
            repeat (N) step_a();
        end
        tb_line = stop;
        repeat (N) step_a();
        tb_line = 1'b1;
        repeat (2 * N) step_a();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30 * N) begin
            @(posedge clk_b);
            n++;
        end
        check("sb_drain", exp_q.size(), 0);
        repeat (N) @(posedge clk_b);
    endtask

    // Scoreboard: every done pulse from B must match the oldest pushed byte.
    initial begin : monitor
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk_b);
            if (bus_b.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%0h required=none", bus_b.rx_data);
                end else begin
                    check("rx_data", bus_b.rx_data, exp_q.pop_front());
                    check("done_width", prev_done, 0);
                end
            end
            prev_done = bus_b.done;
        end
    end

    initial begin : watchdog
        #40_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[6];
        logic [9:0] got;
        int n, low, busy_cyc;

        vecs[0] = '{data: 8'hA5, gap: 1,  frame: 10'b1_10100101_0};
        vecs[1] = '{data: 8'h5A, gap: 3,  frame: 10'b1_01011010_0};
        vecs[2] = '{data: 8'hFF, gap: 10, frame: 10'b1_11111111_0};
        vecs[3] = '{data: 8'h00, gap: 2,  frame: 10'b1_00000000_0};
        vecs[4] = '{data: 8'hC3, gap: 5,  frame: 10'b1_11000011_0};
        vecs[5] = '{data: 8'h3C, gap: 7,  frame: 10'b1_00111100_0};

        bus_a.tx_st   = 1'b0;
        bus_a.tx_data = 8'h00;
        bus_b.tx_st   = 1'b0;
        bus_b.tx_data = 8'h00;
        #5 rst = 1'b0;
        repeat (5) step_a();
        check("rst_tx_serial", a_tx_serial, 1);
        check("rst_tx_busy", bus_a.tx_busy, 0);
        check("rst_done", bus_b.done, 0);
        check("rst_rx_data", bus_b.rx_data, 0);
        rst = 1'b1;
        repeat (5) step_a();

        // Loopback vectors with frame-shape check on the wire.
        for (int i = 0; i < 6; i++) begin
            start_tx(vecs[i].data);
            exp_q.push_back(vecs[i].data);
            repeat (N / 2) step_a();
            for (int b = 0; b < 10; b++) begin
                got[b] = a_tx_serial;
                if (b < 9) repeat (N) step_a();
            end
            check("tx_frame", got, vecs[i].frame);
            repeat (N / 2 + vecs[i].gap * N) step_a();
        end
        drain();

        // Back-to-back with tx_st held high; data changed after capture.
        wait_idle_a();
        step_a();
        bus_a.tx_st   = 1'b1;
        bus_a.tx_data = 8'h55;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        step_a();
        bus_a.tx_data = 8'hAA;
        n = 0;
        while (bus_a.tx_busy && n < 12 * N) begin
            step_a();
            n++;
        end
        low = 0;
        while (!bus_a.tx_busy && low < 4) begin
            step_a();
            low++;
        end
        bus_a.tx_st = 1'b0;
        check("b2b_gap_le1", int'(n < 12 * N && low <= 1), 1);
        check("b2b_second_busy", bus_a.tx_busy, 1);
        wait_idle_a();
        repeat (2 * N) step_a();
        check("b2b_no_third", bus_a.tx_busy, 0);
        drain();

        // Request while busy is ignored; frame length stays 10 bit periods.
        start_tx(8'h34);
        exp_q.push_back(8'h34);
        busy_cyc = 1;
        for (int j = 0; j < 12 * N && bus_a.tx_busy; j++) begin
            bus_a.tx_st   = (j == 3 * N);
            bus_a.tx_data = 8'h12;
            step_a();
            if (bus_a.tx_busy) busy_cyc++;
        end
        bus_a.tx_st = 1'b0;
        check("busy_len", busy_cyc, 10 * N);
        repeat (2 * N) step_a();
        check("no_extra_frame", bus_a.tx_busy, 0);
        drain();

        // Short low glitch on rx, then a valid frame.
        drive_sel = 1'b1;
        tb_line   = 1'b1;
        repeat (N) step_a();
        tb_line = 1'b0;
        repeat (4) step_a();
        tb_line = 1'b1;
        repeat (3 * N) step_a();
        check("glitch_hold", bus_b.rx_data, 8'h34);
        exp_q.push_back(8'h81);
        send_rx_frame(8'h81, 1'b1);
        drain();

        // Framing error keeps old data; next frame decodes.
        send_rx_frame(8'h3C, 1'b0);
        repeat (N) step_a();
        check("frame_err_hold", bus_b.rx_data, 8'h81);
        exp_q.push_back(8'h7E);
        send_rx_frame(8'h7E, 1'b1);
        drain();

        // Reset mid-frame aborts both paths.
        drive_sel = 1'b0;
        repeat (N) step_a();
        start_tx(8'h5A);
        repeat (4 * N) step_a();
        rst = 1'b0;
        #1;
        check("midrst_tx_serial", a_tx_serial, 1);
        check("midrst_tx_busy", bus_a.tx_busy, 0);
        check("midrst_done", bus_b.done, 0);
        check("midrst_rx_data", bus_b.rx_data, 0);
        repeat (3) step_a();
        rst = 1'b1;
        repeat (3) step_a();
        start_tx(8'hA5);
        exp_q.push_back(8'hA5);
        wait_idle_a();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
